// File: rtl/matrix_mult_pkg.sv
// Shared types and width helpers for the sequential N x N matrix multiplier.
package matrix_mult_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } mm_state_t;

  // Bits needed to index n items; never less than one.
  function automatic int mm_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Result width wide enough for N full-scale products without overflow.
  function automatic int mm_out_w(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac_unit.sv
// Multiply-accumulate slice: extends both operands to OW bits, then loads or
// accumulates their product.
module mac_unit #(
  parameter int W  = 2,
  parameter int OW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          clear,
  input  logic          en,
  input  logic          signed_mode,
  output logic [OW-1:0] acc
);

  logic [OW-1:0] a_ext_s;
  logic [OW-1:0] b_ext_s;
  logic [OW-1:0] prod_s;

  // Operand extension; an OW-bit wrapped product is exact in both modes.
  always_comb begin
    if (signed_mode) begin
      a_ext_s = {{(OW-W){a[W-1]}}, a};
      b_ext_s = {{(OW-W){b[W-1]}}, b};
    end else begin
      a_ext_s = {{(OW-W){1'b0}}, a};
      b_ext_s = {{(OW-W){1'b0}}, b};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= {OW{1'b0}};
    end else if (en) begin
      if (clear) begin
        acc <= prod_s;
      end else begin
        acc <= acc + prod_s;
      end
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential C = A*B over streamed N x N matrices with one time-shared MAC.
// Elements arrive A then B row-major; results leave row-major.
module matrix_mult_seq
  import matrix_mult_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = 2,
  parameter int OW = mm_out_w(N, W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          signed_mode,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int NN = N * N;
  localparam int IW = mm_idx_w(N);
  localparam int EW = mm_idx_w(NN);
  localparam int LW = mm_idx_w(2 * NN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [LW-1:0] LAST_LOAD = LW'(2 * NN - 1);
  localparam logic [LW-1:0] NN_L      = LW'(NN);
  localparam logic [EW-1:0] LAST_OUT  = EW'(NN - 1);

  mm_state_t     state_r, state_next_s;
  logic [LW-1:0] load_cnt_r;
  logic [IW-1:0] i_r, j_r, k_r;
  logic [EW-1:0] out_idx_r, wr_idx_r, a_idx_s, b_idx_s;
  logic          wr_pend_r, signed_r, in_ready_r, out_valid_r, busy_r;
  logic [OW-1:0] out_data_r, acc_s;
  logic [W-1:0]  a_mem_r [NN];
  logic [W-1:0]  b_mem_r [NN];
  logic [OW-1:0] c_mem_r [NN];
  logic          load_fire_s, out_fire_s, mac_en_s, mac_clear_s, last_k_s, last_mac_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Next-state and MAC control decode.
  always_comb begin
    load_fire_s  = in_valid & in_ready_r;
    out_fire_s   = out_valid_r & out_ready;
    last_k_s     = (k_r == LAST_IDX);
    last_mac_s   = last_k_s && (i_r == LAST_IDX) && (j_r == LAST_IDX);
    a_idx_s      = EW'(int'(i_r) * N + int'(k_r));
    b_idx_s      = EW'(int'(k_r) * N + int'(j_r));
    mac_en_s     = 1'b0;
    mac_clear_s  = 1'b0;
    state_next_s = state_r;
    case (state_r)
      LOAD: begin
        if (load_fire_s && (load_cnt_r == LAST_LOAD)) state_next_s = COMPUTE;
        else                                          state_next_s = LOAD;
      end
      COMPUTE: begin
        mac_en_s    = 1'b1;
        mac_clear_s = (k_r == {IW{1'b0}});
        if (last_mac_s) state_next_s = OUTPUT;
        else            state_next_s = COMPUTE;
      end
      OUTPUT: begin
        if (out_fire_s && (out_idx_r == LAST_OUT)) state_next_s = LOAD;
        else                                       state_next_s = OUTPUT;
      end
      default: state_next_s = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= LOAD;
    else       state_r <= state_next_s;
  end

  // Counters, latched mode and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_r  <= {LW{1'b0}};
      i_r         <= {IW{1'b0}};
      j_r         <= {IW{1'b0}};
      k_r         <= {IW{1'b0}};
      out_idx_r   <= {EW{1'b0}};
      wr_idx_r    <= {EW{1'b0}};
      wr_pend_r   <= 1'b0;
      signed_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {OW{1'b0}};
    end else begin
      in_ready_r <= (state_next_s == LOAD);
      busy_r     <= (state_next_s != LOAD);
      if (load_fire_s) begin
        if (load_cnt_r == {LW{1'b0}}) signed_r <= signed_mode;
        if (load_cnt_r == LAST_LOAD) load_cnt_r <= {LW{1'b0}};
        else                         load_cnt_r <= load_cnt_r + 1'b1;
      end
      if (mac_en_s) begin
        if (last_k_s) begin
          k_r <= {IW{1'b0}};
          if (j_r == LAST_IDX) begin
            j_r <= {IW{1'b0}};
            if (i_r == LAST_IDX) i_r <= {IW{1'b0}};
            else                 i_r <= i_r + 1'b1;
          end else begin
            j_r <= j_r + 1'b1;
          end
        end else begin
          k_r <= k_r + 1'b1;
        end
      end
      // The accumulator holds the finished dot product one cycle after k=N-1.
      wr_pend_r <= mac_en_s & last_k_s;
      wr_idx_r  <= EW'(int'(i_r) * N + int'(j_r));
      if (state_r == OUTPUT) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= c_mem_r[0];
          out_idx_r   <= {EW{1'b0}};
        end else if (out_fire_s) begin
          if (out_idx_r == LAST_OUT) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= {EW{1'b0}};
          end else begin
            out_idx_r  <= out_idx_r + 1'b1;
            out_data_r <= c_mem_r[out_idx_r + 1'b1];
          end
        end
      end
    end
  end

  // Matrix storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (load_fire_s) begin
      if (load_cnt_r < NN_L) a_mem_r[EW'(load_cnt_r)]        <= in_data;
      else                   b_mem_r[EW'(load_cnt_r - NN_L)] <= in_data;
    end
    if (wr_pend_r) c_mem_r[wr_idx_r] <= acc_s;
  end

  mac_unit #(.W(W), .OW(OW)) u_mac (
    .clk         (clk),
    .reset       (reset),
    .a           (a_mem_r[a_idx_s]),
    .b           (b_mem_r[b_idx_s]),
    .clear       (mac_clear_s),
    .en          (mac_en_s),
    .signed_mode (signed_r),
    .acc         (acc_s)
  );

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed self-checking bench for matrix_mult_seq: an N=2 W=2 instance for
// the main scenarios and an N=3 W=4 instance for the parameter sweep.
module tb_matrix_mult_seq;

  typedef int vec4_t[4];
  typedef int vec8_t[8];
  typedef int vec9_t[9];
  typedef int vec18_t[18];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] in_data2;
  logic       in_valid2, in_ready2, sm2, out_valid2, out_ready2, busy2;
  logic [4:0] out_data2;
  logic [3:0] in_data3;
  logic       in_valid3, in_ready3, sm3, out_valid3, out_ready3, busy3;
  logic [9:0] out_data3;

  int checks = 0;
  int failures = 0;

  matrix_mult_seq #(.N(2), .W(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .signed_mode(sm2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  matrix_mult_seq #(.N(3), .W(4)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .signed_mode(sm3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send2(input int d, input logic sm);
    int n = 0;
    in_data2 = 2'(d); sm2 = sm; in_valid2 = 1'b1;
    while (!in_ready2 && n < 200) begin @(negedge clk); n++; end
    check("send2_ready", 32'(in_ready2), 32'd1);
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  task automatic load2(input vec8_t m, input logic sm);
    for (int i = 0; i < 8; i++) send2(m[i], (i == 0) ? sm : ~sm);
    check("busy_in_compute2", 32'({busy2, in_ready2}), 32'(2'b10));
  endtask

  task automatic wait_out2(output int n);
    n = 0;
    while (!out_valid2 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic recv2(input int exp, input int stall, input string tag);
    int n = 0;
    out_ready2 = 1'b0;
    while (!out_valid2 && n < 200) begin @(negedge clk); n++; end
    for (int s = 0; s < stall; s++) begin
      check({tag, "_held"}, 32'({out_valid2, out_data2}), 32'({1'b1, 5'(exp)}));
      @(negedge clk);
    end
    check(tag, 32'({out_valid2, out_data2}), 32'({1'b1, 5'(exp)}));
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
  endtask

  task automatic job2(input vec8_t m, input logic sm, input vec4_t c, input string tag);
    int n;
    load2(m, sm);
    wait_out2(n);
    check({tag, "_latency"}, 32'(n), 32'd9);
    for (int r = 0; r < 4; r++) recv2(c[r], 0, tag);
  endtask

  task automatic send3(input int d, input logic sm);
    int n = 0;
    in_data3 = 4'(d); sm3 = sm; in_valid3 = 1'b1;
    while (!in_ready3 && n < 200) begin @(negedge clk); n++; end
    check("send3_ready", 32'(in_ready3), 32'd1);
    @(negedge clk);
    in_valid3 = 1'b0;
  endtask

  task automatic job3(input vec18_t m, input logic sm, input vec9_t c, input string tag);
    int n = 0;
    for (int i = 0; i < 18; i++) send3(m[i], (i == 0) ? sm : ~sm);
    while (!out_valid3 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd28);
    for (int r = 0; r < 9; r++) begin
      check(tag, 32'({out_valid3, out_data3}), 32'({1'b1, 10'(c[r])}));
      out_ready3 = 1'b1;
      @(negedge clk);
      out_ready3 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t  m_t1, m_max, m_neg, m_sgn;
    vec4_t  c_t1, c_max, c_neg, c_sgn;
    vec18_t m3s, m3u;
    vec9_t  c3s, c3u;
    int     n;

    m_t1  = '{1, 2, 3, 0, 2, 1, 0, 3};          c_t1  = '{2, 7, 6, 3};
    m_max = '{3, 3, 3, 3, 3, 3, 3, 3};          c_max = '{18, 18, 18, 18};
    m_neg = '{-2, -2, -2, -2, -2, -2, -2, -2};  c_neg = '{8, 8, 8, 8};
    m_sgn = '{1, -2, -1, 1, 1, 1, 1, -2};       c_sgn = '{-1, 5, 0, -3};
    m3s = '{1, -2, 3, 0, 4, -5, 7, -8, 2, 2, 0, -1, -3, 1, 6, 4, -7, 5};
    c3s = '{20, -23, 2, -32, 39, -1, 46, -22, -45};
    m3u = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
    c3u = '{675, 675, 675, 675, 675, 675, 675, 675, 675};

    reset = 1'b1;
    in_data2 = 2'd0; in_valid2 = 1'b0; sm2 = 1'b0; out_ready2 = 1'b0;
    in_data3 = 4'd0; in_valid3 = 1'b0; sm3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state2", 32'({in_ready2, out_valid2, busy2, out_data2}), 32'({3'b100, 5'd0}));
    check("reset_state3", 32'({in_ready3, out_valid3, busy3, out_data3}), 32'({3'b100, 10'd0}));

    job2(m_t1, 1'b0, c_t1, "unsigned_basic");
    job2(m_max, 1'b0, c_max, "unsigned_max");
    job2(m_neg, 1'b1, c_neg, "signed_neg2");
    job2(m_sgn, 1'b1, c_sgn, "signed_mixed");

    // Backpressure on result index 1, with in_valid held high meanwhile.
    load2(m_t1, 1'b0);
    in_data2 = 2'd1; in_valid2 = 1'b1;
    wait_out2(n);
    check("bp_latency", 32'(n), 32'd9);
    recv2(2, 0, "bp_r0");
    recv2(7, 5, "bp_r1");
    recv2(6, 0, "bp_r2");
    recv2(3, 0, "bp_r3");
    check("bp_back_to_load", 32'({in_ready2, out_valid2}), 32'(2'b10));
    in_valid2 = 1'b0;
    job2(m_sgn, 1'b1, c_sgn, "after_bp");

    // Reset after 3 of 8 inputs.
    send2(3, 1'b0); send2(3, 1'b0); send2(3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_midload", 32'({in_ready2, out_valid2, busy2}), 32'(3'b100));
    job2(m_t1, 1'b0, c_t1, "after_reset_load");

    // Reset while result index 2 is pending.
    load2(m_max, 1'b0);
    wait_out2(n);
    recv2(18, 0, "pre_reset_r0");
    recv2(18, 0, "pre_reset_r1");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_midout", 32'({in_ready2, out_valid2, busy2, out_data2}), 32'({3'b100, 5'd0}));
    job2(m_sgn, 1'b1, c_sgn, "after_reset_out");

    job3(m3s, 1'b1, c3s, "n3_signed");
    job3(m3u, 1'b0, c3u, "n3_unsigned_max");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
